scanout_reader: RTL and testbench

- Display-side reader of the framebuffer held in SDRAM; the read counterpart of the draw path that writes rectangles through write bursts.
- Walks the frame linearly from FB_BASE and issues read bursts to the SDRAM controller's read port. It buffers the returned RGB565 words in a local FIFO.
- Serves one pixel per pixel_req from the VGA timing generator.
- Sits between the SDRAM controller read port and the VGA output stage.

---
 rtl/scanout_pkg.sv | 7 +
 rtl/scanout_fifo.sv | 49 ++++
 rtl/scanout_reader.sv | 100 ++++++++++
 tb/tb_scanout_reader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/scanout_pkg.sv
// scanout_pkg: shared widths and FSM encoding for the framebuffer scanout path
package scanout_pkg;
  localparam int RGB_W = 16;
  localparam int ADDR_W = 22;
  localparam int LEN_W = 10;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DATA} state_t;
endpackage

// File: rtl/scanout_fifo.sv
// scanout_fifo: synchronous FIFO with registered read data, count, full and empty
module scanout_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // storage array, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // pointers, occupancy and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      dout <= '0;
    end else begin
      if (do_pop) dout <= mem[rd];
      if (flush) begin
        wr <= '0;
        rd <= '0;
        count <= '0;
      end else begin
        wr <= wr + AW'(do_push);
        rd <= rd + AW'(do_pop);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end
endmodule

// File: rtl/scanout_reader.sv
// scanout_reader: streams the framebuffer from SDRAM into a line FIFO for VGA
module scanout_reader
  import scanout_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BURST_LEN = 64,
  parameter int FIFO_DEPTH = 256,
  parameter logic [ADDR_W-1:0] FB_BASE = 22'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              pixel_req,
  output logic [RGB_W-1:0]  pixel_rgb,
  output logic              pixel_valid,
  output logic              underflow,
  output logic              read_burst_req,
  output logic [LEN_W-1:0]  read_burst_len,
  output logic [ADDR_W-1:0] read_addr,
  input  logic              read_burst_data_valid,
  input  logic [RGB_W-1:0]  read_burst_data,
  input  logic              read_burst_data_finish,
  output logic              busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] TOTAL = ADDR_W'(H_ACTIVE * V_ACTIVE);
  state_t state, nxt;
  logic [ADDR_W-1:0] ptr, rem;
  logic pend, finish, restart, push, pop, space_ok, full, empty;
  logic [CW-1:0] count;
  logic [RGB_W-1:0] dout;
  assign busy = state == S_REQ || state == S_DATA;
  assign read_burst_req = busy;
  assign finish = state == S_DATA && read_burst_data_finish;
  assign restart = (frame_start && !busy) || (finish && (pend || frame_start));
  assign push = state == S_DATA && read_burst_data_valid && !pend && !frame_start;
  assign pop = pixel_req && !empty && !frame_start;
  assign space_ok = !full && count <= CW'(FIFO_DEPTH - BURST_LEN);
  assign pixel_rgb = pixel_valid ? dout : '0;
  scanout_fifo #(.W(RGB_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(restart),
    .push(push),
    .din(read_burst_data),
    .pop(pop),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // next-state: one burst at a time, only with room for a full burst
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = enable && rem != '0 ? S_CHECK : S_IDLE;
      S_CHECK: nxt = !enable ? S_IDLE : space_ok ? S_REQ : S_CHECK;
      S_REQ:   nxt = S_DATA;
      S_DATA:  nxt = read_burst_data_finish ? S_IDLE : S_DATA;
    endcase
    if (restart) nxt = S_IDLE;
  end
  // frame walk, burst latching, deferred restart and pop status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= FB_BASE;
      rem <= TOTAL;
      read_addr <= '0;
      read_burst_len <= '0;
      pend <= 1'b0;
      underflow <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= pop;
      if (state == S_CHECK && enable && space_ok) begin
        read_addr <= ptr;
        read_burst_len <= rem < ADDR_W'(BURST_LEN) ? LEN_W'(rem) : LEN_W'(BURST_LEN);
      end
      if (restart) begin
        ptr <= FB_BASE;
        rem <= TOTAL;
        pend <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (finish) begin
          ptr <= ptr + ADDR_W'(read_burst_len);
          rem <= rem - ADDR_W'(read_burst_len);
        end
        if (frame_start && busy) pend <= 1'b1;
        if (pixel_req && empty && !frame_start) underflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scanout_reader.sv
// tb_scanout_reader: directed bench with a model SDRAM read port returning word = address
module tb_scanout_reader;
  localparam logic [21:0] FB = 22'h100;
  logic clk, rst_n, enable, frame_start, pixel_req;
  logic [15:0] pixel_rgb;
  logic pixel_valid, underflow, read_burst_req, busy;
  logic [9:0] read_burst_len;
  logic [21:0] read_addr;
  logic read_burst_data_valid, read_burst_data_finish;
  logic [15:0] read_burst_data;
  int tests = 0, fails = 0, gap = 0, vcnt = 0;
  int mst = 0, mw = 0, mi = 0;
  logic [21:0] maddr;
  logic [9:0] mlen;
  logic req_d = 0;
  logic [21:0] bursts[$];
  logic [9:0] blens[$];
  logic [15:0] pix[$];

  scanout_reader #(.H_ACTIVE(8), .V_ACTIVE(4), .BURST_LEN(8), .FIFO_DEPTH(16), .FB_BASE(FB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start), .pixel_req(pixel_req),
    .pixel_rgb(pixel_rgb), .pixel_valid(pixel_valid), .underflow(underflow),
    .read_burst_req(read_burst_req), .read_burst_len(read_burst_len), .read_addr(read_addr),
    .read_burst_data_valid(read_burst_data_valid), .read_burst_data(read_burst_data),
    .read_burst_data_finish(read_burst_data_finish), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model controller: 3 cycles request-to-data, optional gaps, finish after last word
  initial begin
    read_burst_data_valid = 0;
    read_burst_data_finish = 0;
    read_burst_data = 0;
    forever begin
      @(negedge clk);
      read_burst_data_valid = 0;
      read_burst_data_finish = 0;
      if (!rst_n) mst = 0;
      else case (mst)
        0: if (read_burst_req) begin maddr = read_addr; mlen = read_burst_len; mi = 0; mw = 2; mst = 1; end
        1: if (mw > 0) mw--;
           else begin
             read_burst_data_valid = 1;
             read_burst_data = 16'(maddr + 22'(mi));
             mi++;
             mw = gap;
             if (mi == int'(mlen)) mst = 2;
           end
        default: begin read_burst_data_finish = 1; mst = 0; end
      endcase
    end
  end

  // burst and pixel logging just after each active edge
  always @(posedge clk) begin
    #1;
    if (read_burst_req && !req_d) begin bursts.push_back(read_addr); blens.push_back(read_burst_len); end
    if (pixel_valid) pix.push_back(pixel_rgb);
    req_d = read_burst_req;
  end

  // handshake and overflow protocol checks
  always @(posedge clk) begin
    if (!rst_n) vcnt = 0;
    else begin
      if (read_burst_data_valid) vcnt++;
      if (read_burst_data_finish) begin
        assert (vcnt == int'(read_burst_len));
        vcnt = 0;
      end
      assert (!(dut.push && dut.full));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_frame;
    frame_start = 1;
    tick(1);
    frame_start = 0;
  endtask

  task automatic pop_until(input int n, input bit every);
    for (int t = 0; t < 1000 && pix.size() < n; t++) begin
      pixel_req = every || !t[0];
      tick(1);
    end
    pixel_req = 0;
    tick(2);
  endtask

  task automatic check_seq(input string tag, input int n);
    check({tag, "_count"}, pix.size(), n);
    for (int i = 0; i < n && i < pix.size(); i++) check(tag, 32'(pix[i]), 32'(FB) + 32'(i));
  endtask

  task automatic clear_logs;
    bursts.delete();
    blens.delete();
    pix.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; enable = 0; frame_start = 0; pixel_req = 0;
    tick(3);
    check("rst_req", read_burst_req, 0);
    check("rst_busy", busy, 0);
    check("rst_pv", pixel_valid, 0);
    check("rst_uf", underflow, 0);
    check("rst_rgb", pixel_rgb, 0);
    check("rst_addr", read_addr, 0);
    check("rst_len", read_burst_len, 0);
    rst_n = 1;
    tick(1);
    // pop from empty FIFO right after reset
    pixel_req = 1;
    tick(1);
    pixel_req = 0;
    check("empty_pv", pixel_valid, 0);
    check("empty_rgb", pixel_rgb, 0);
    check("empty_uf", underflow, 1);
    // fill: two bursts, then stall with the FIFO full
    enable = 1;
    tick(80);
    check("fill_nbursts", bursts.size(), 2);
    check("fill_addr0", bursts[0], 22'h100);
    check("fill_len0", blens[0], 8);
    check("fill_addr1", bursts[1], 22'h108);
    check("fill_len1", blens[1], 8);
    check("fill_count", 32'(dut.count), 16);
    check("uf_sticky", underflow, 1);
    // frame_start while idle: flush and clear underflow
    clear_logs();
    pulse_frame();
    check("fs_uf_clr", underflow, 0);
    check("fs_flush", 32'(dut.count), 0);
    tick(80);
    pop_until(32, 0);
    check_seq("frame_pix", 32);
    check("frame_nbursts", bursts.size(), 4);
    check("frame_addr1", bursts[1], 22'h108);
    check("frame_addr2", bursts[2], 22'h110);
    check("frame_addr3", bursts[3], 22'h118);
    check("frame_uf", underflow, 0);
    tick(30);
    check("done_nbursts", bursts.size(), 4);
    check("done_req", read_burst_req, 0);
    // frame_start during the data phase of the 0x108 burst
    clear_logs();
    pulse_frame();
    for (int t = 0; t < 200 && !(read_burst_req && read_addr == 22'h108); t++) tick(1);
    check("fsb_seen", read_burst_req && read_addr == 22'h108, 1);
    tick(4);
    pulse_frame();
    check("fsb_pending_busy", busy, 1);
    tick(80);
    check("fsb_restart_addr", bursts[2], 22'h100);
    pop_until(16, 0);
    check_seq("fsb_pix", 16);
    // gapped data with a pop every cycle
    gap = 2;
    pulse_frame();
    tick(250);
    clear_logs();
    check("gap_fill", 32'(dut.count), 16);
    pop_until(32, 1);
    check_seq("gap_pix", 32);
    check("gap_count_end", 32'(dut.count), 0);
    // asynchronous reset mid-burst
    gap = 0;
    pulse_frame();
    for (int t = 0; t < 200 && !(read_burst_req && read_addr == 22'h108); t++) tick(1);
    pixel_req = 1;
    tick(1);
    check("ar_pv_pre", pixel_valid, 1);
    check("ar_req_pre", read_burst_req, 1);
    #2 rst_n = 0;
    #1;
    check("ar_req", read_burst_req, 0);
    check("ar_busy", busy, 0);
    check("ar_pv", pixel_valid, 0);
    check("ar_count", 32'(dut.count), 0);
    pixel_req = 0;
    tick(2);
    clear_logs();
    rst_n = 1;
    tick(40);
    check("ar_restart_n", bursts.size() >= 1, 1);
    if (bursts.size() >= 1) check("ar_restart_addr", bursts[0], 22'h100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
